// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller for the Hack CPU.
// Sequences IDLE -> FETCH -> EXEC, strobes pc_inc / pc_load and counts
// retired instructions. All outputs are registered (Moore).
// Optional build macro: HALT_LOOP_DETECT_EN (jump-to-self halts the sequencer).
module pc_sequencer #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [14:0]      pc_value,
  input  logic [14:0]      a_reg,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             fetch_req,
  output logic             exec_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [14:0]      pc_in,
  output logic             busy,
  output logic             fault,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [8:0] LP_MAX_WAIT = 9'(MAX_WAIT);

  logic [1:0]       r_state;
  logic [7:0]       r_wait;
  logic             r_single;
  logic             r_self_loop;
  logic             r_fetch_req;
  logic             r_exec_en;
  logic             r_pc_inc;
  logic             r_pc_load;
  logic [14:0]      r_pc_in;
  logic             r_busy;
  logic             r_fault;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic [1:0] w_state_nx;
  logic [7:0] w_wait_nx;
  logic [8:0] w_wait_inc;
  logic       w_single_nx;
  logic       w_fault_set;
  logic       w_enter_exec;
  logic       w_jump_hit;
  logic       w_take;
  logic       w_self;
  logic       w_unused_bits;

  // Jump decision from the instruction word as it is latched (FETCH -> EXEC edge):
  // j1 = less-than, j2 = equal, j3 = greater-than.
  assign w_jump_hit = (instr[2] & alu_ng) |
                      (instr[1] & alu_zr) |
                      (instr[0] & ~alu_ng & ~alu_zr);
  assign w_take     = instr[15] & w_jump_hit;
  assign w_wait_inc = {1'b0, r_wait} + 9'd1;

`ifdef HALT_LOOP_DETECT_EN
  assign w_self        = w_take & (a_reg == pc_value);
  assign w_unused_bits = ^instr[14:3];
`else
  assign w_self        = 1'b0;
  assign w_unused_bits = ^{instr[14:3], pc_value};
`endif

  // Next-state and bookkeeping decisions
  always_comb begin
    w_state_nx  = r_state;
    w_wait_nx   = r_wait;
    w_single_nx = r_single;
    w_fault_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nx  = S_FETCH;
          w_single_nx = 1'b0;
          w_wait_nx   = '0;
        end else if (step) begin
          w_state_nx  = S_FETCH;
          w_single_nx = 1'b1;
          w_wait_nx   = '0;
        end
      end
      S_FETCH: begin
        if (instr_valid) begin
          w_state_nx = S_EXEC;
        end else if (w_wait_inc == LP_MAX_WAIT) begin
          w_state_nx  = S_HALT;
          w_fault_set = 1'b1;
        end else begin
          w_wait_nx = w_wait_inc[7:0];
        end
      end
      S_EXEC: begin
        if (r_self_loop) begin
          w_state_nx = S_HALT;
        end else if (r_single || !run) begin
          w_state_nx  = S_IDLE;
          w_single_nx = 1'b0;
        end else begin
          w_state_nx = S_FETCH;
          w_wait_nx  = '0;
        end
      end
      default: w_state_nx = S_HALT;
    endcase
  end

  assign w_enter_exec = (r_state == S_FETCH) && (w_state_nx == S_EXEC);

  // State, counters and registered Moore outputs; the strobes of EXEC are
  // decided on the edge that enters EXEC so they appear in that single cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_single    <= 1'b0;
      r_self_loop <= 1'b0;
      r_fetch_req <= 1'b0;
      r_exec_en   <= 1'b0;
      r_pc_inc    <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_in     <= '0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_halted    <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_wait      <= w_wait_nx;
      r_single    <= w_single_nx;
      r_self_loop <= w_enter_exec & w_self;
      r_fetch_req <= (w_state_nx == S_FETCH);
      r_exec_en   <= (w_state_nx == S_EXEC);
      r_pc_inc    <= w_enter_exec & ~w_take;
      r_pc_load   <= w_enter_exec & w_take;
      r_busy      <= (w_state_nx == S_FETCH) || (w_state_nx == S_EXEC);
      r_halted    <= (w_state_nx == S_HALT);
      if (w_enter_exec && w_take) r_pc_in <= a_reg;
      if (w_enter_exec) r_retired <= r_retired + 1'b1;
      if (w_fault_set) r_fault <= 1'b1;
    end
  end

  assign fetch_req = r_fetch_req;
  assign exec_en   = r_exec_en;
  assign pc_inc    = r_pc_inc;
  assign pc_load   = r_pc_load;
  assign pc_in     = r_pc_in;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign halted    = r_halted;
  assign retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a transaction-level reference model.
module tb_pc_sequencer;

  localparam int unsigned MAX_WAIT = 16;
  localparam int unsigned CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst, run, step, instr_valid, alu_zr, alu_ng;
  logic [14:0]      pc_value, a_reg;
  logic [15:0]      instr;
  logic             fetch_req, exec_en, pc_inc, pc_load, busy, fault, halted;
  logic [14:0]      pc_in;
  logic [CNT_W-1:0] retired;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pc_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .pc_value(pc_value),
    .a_reg(a_reg), .instr(instr), .instr_valid(instr_valid),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .fetch_req(fetch_req),
    .exec_en(exec_en), .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
    .busy(busy), .fault(fault), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference model: which activity the controller is in, plus its outputs
  typedef enum int {IDLING, WAITING_ROM, EXECUTING, STOPPED} activity_t;
  activity_t   m_act;
  int unsigned m_stall;
  bit          m_one_shot, m_stop_after, m_jumped, m_fault;
  int unsigned m_target, m_retired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit jump_taken(input logic [15:0] ins, input bit zr, input bit ng);
    bit lt, eq, gt;
    if (!ins[15]) return 1'b0;
    lt = ng; eq = zr; gt = !ng && !zr;
    return (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_act = IDLING; m_stall = 0; m_one_shot = 0; m_stop_after = 0;
      m_jumped = 0; m_fault = 0; m_target = 0; m_retired = 0;
      return;
    end
    case (m_act)
      IDLING: begin
        if (run)       begin m_act = WAITING_ROM; m_one_shot = 0; m_stall = 0; end
        else if (step) begin m_act = WAITING_ROM; m_one_shot = 1; m_stall = 0; end
      end
      WAITING_ROM: begin
        if (instr_valid) begin
          m_act     = EXECUTING;
          m_jumped  = jump_taken(instr, alu_zr, alu_ng);
          if (m_jumped) m_target = a_reg;
          m_retired = m_retired + 1;
`ifdef HALT_LOOP_DETECT_EN
          m_stop_after = m_jumped && (a_reg == pc_value);
`else
          m_stop_after = 0;
`endif
        end else begin
          m_stall++;
          if (m_stall >= MAX_WAIT) begin m_act = STOPPED; m_fault = 1; end
        end
      end
      EXECUTING: begin
        if (m_stop_after)               m_act = STOPPED;
        else if (m_one_shot || !run)    begin m_act = IDLING; m_one_shot = 0; end
        else                            begin m_act = WAITING_ROM; m_stall = 0; end
      end
      default: m_act = STOPPED;
    endcase
  endtask

  // Advance one clock: model consumes the current inputs, DUT outputs checked 1ns after the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("fetch_req", 32'(fetch_req), 32'(m_act == WAITING_ROM));
    chk("exec_en",   32'(exec_en),   32'(m_act == EXECUTING));
    chk("pc_inc",    32'(pc_inc),    32'(m_act == EXECUTING && !m_jumped));
    chk("pc_load",   32'(pc_load),   32'(m_act == EXECUTING && m_jumped));
    chk("pc_in",     32'(pc_in),     m_target);
    chk("busy",      32'(busy),      32'(m_act == WAITING_ROM || m_act == EXECUTING));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("halted",    32'(halted),    32'(m_act == STOPPED));
    chk("retired",   retired,        m_retired);
  endtask

  task automatic set_in(input bit r, input bit s, input logic [15:0] ins, input bit v,
                        input logic [14:0] a, input logic [14:0] pc, input bit zr, input bit ng);
    run = r; step = s; instr = ins; instr_valid = v;
    a_reg = a; pc_value = pc; alu_zr = zr; alu_ng = ng;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned stall_left;
    int unsigned stopped_for;
    rst = 1'b1;
    set_in(0, 0, 16'h0000, 0, 15'h0, 15'h0, 0, 0);
    m_act = IDLING; m_stall = 0; m_one_shot = 0; m_stop_after = 0;
    m_jumped = 0; m_fault = 0; m_target = 0; m_retired = 0;
    @(negedge clk);

    // Reset state
    do_reset();

    // Free-run A-instruction with zero-wait ROM, then stop
    set_in(1, 0, 16'h0005, 1, 15'h0, 15'h0, 0, 0);
    tick(); tick();
    run = 0;
    tick(); tick();

    // JEQ taken then not taken
    set_in(1, 0, 16'hE302, 1, 15'h0010, 15'h0003, 1, 0);
    tick(); tick();
    alu_zr = 0;
    tick(); tick();
    run = 0;
    tick(); tick();

    // Two single steps with run low
    repeat (2) begin
      set_in(0, 1, 16'h0007, 1, 15'h0, 15'h0, 0, 0);
      tick();
      step = 0;
      repeat (4) tick();
    end

    // Fetch timeout: instr_valid held low, then halted state ignores everything
    set_in(1, 0, 16'h0001, 0, 15'h0, 15'h0, 0, 0);
    repeat (MAX_WAIT + 3) tick();
    set_in(1, 1, 16'hE307, 1, 15'h0022, 15'h0, 0, 0);
    repeat (4) tick();
    do_reset();

    // 0;JMP to self
    set_in(1, 0, 16'hEA87, 1, 15'h0004, 15'h0004, 0, 0);
    repeat (10) tick();
    do_reset();

    // Random stimulus
    stall_left  = 0;
    stopped_for = 0;
    for (int unsigned c = 0; c < 4000; c++) begin
      run         = ($urandom % 8) != 0;
      step        = ($urandom % 4) == 0;
      instr       = 16'($urandom);
      a_reg       = 15'($urandom);
      pc_value    = (($urandom % 4) == 0) ? a_reg : 15'($urandom);
      alu_zr      = 1'($urandom);
      alu_ng      = 1'($urandom);
      if (stall_left == 0 && ($urandom % 250) == 0)
        stall_left = 12 + ($urandom % 8);
      if (stall_left != 0) begin
        instr_valid = 1'b0;
        stall_left--;
      end else begin
        instr_valid = ($urandom % 4) != 0;
      end
      stopped_for = (m_act == STOPPED) ? stopped_for + 1 : 0;
      rst = (($urandom % 300) == 0) || (stopped_for > 6);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
